// File: rtl/muldiv_if.sv
// muldiv_if: issue/result bundle between the core controller and muldiv_unit.
// The controller side drives the request; the unit side returns status and result.
interface muldiv_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            busy;
    logic            exdone;
    logic [XLEN-1:0] result;

    modport master (
        output start, op, rs1, rs2,
        input  busy, exdone, result
    );

    modport slave (
        input  start, op, rs1, rs2,
        output busy, exdone, result
    );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M/RV64M multiply/divide unit.
// Multiply is radix-2 shift-add on operand magnitudes into a 2*XLEN
// accumulator. Divide is restoring division on magnitudes. The sign is
// re-applied in the FIX state. Divide-by-zero and signed overflow are
// resolved at issue and skip the datapath entirely.
// Optional build macro MULDIV_FASTMUL_EN: multiplies use a single-cycle
// combinational product registered at issue (IDLE -> DONE). Without it
// no multiply operator is present in the design.
module muldiv_unit #(
    parameter int XLEN = 32,
    parameter int CNTW = $clog2(XLEN) + 1
) (
    input logic     clk,
    input logic     rst,
    muldiv_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10,
        ST_DONE = 2'b11
    } state_t;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    localparam logic [XLEN-1:0]   ZERO_X = {XLEN{1'b0}};
    localparam logic [XLEN-1:0]   ONES_X = {XLEN{1'b1}};
    localparam logic [XLEN-1:0]   ONE_X  = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0]   MIN_X  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [2*XLEN-1:0] ONE_2X = {{(2*XLEN-1){1'b0}}, 1'b1};
    localparam logic [CNTW-1:0]   CNT_LOAD = CNTW'(XLEN);
    localparam logic [CNTW-1:0]   CNT_ONE  = {{(CNTW-1){1'b0}}, 1'b1};

    // Two's complement negation helpers.
    function automatic logic [XLEN-1:0] neg_x(input logic [XLEN-1:0] v);
        return ~v + ONE_X;
    endfunction

    function automatic logic [2*XLEN-1:0] neg_2x(input logic [2*XLEN-1:0] v);
        return ~v + ONE_2X;
    endfunction

    // Magnitude of an operand, honouring whether it is read as signed.
    function automatic logic [XLEN-1:0] mag_x(input logic [XLEN-1:0] v, input logic sgn);
        return (sgn && v[XLEN-1]) ? neg_x(v) : v;
    endfunction

    // Registers
    state_t            state_r;
    state_t            state_nx;
    logic [CNTW-1:0]   cnt_r;
    logic [2*XLEN-1:0] acc_r;      // mul: {hi, lo/multiplier}; div: {0, quotient}
    logic [XLEN-1:0]   rem_r;      // divide partial remainder (settled part)
    logic [XLEN-1:0]   opa_r;      // multiplicand magnitude
    logic [XLEN-1:0]   opb_r;      // divisor magnitude
    logic [2:0]        op_r;
    logic              neg_res_r;  // negate product / quotient in FIX
    logic              neg_rem_r;  // negate remainder in FIX
    logic [XLEN-1:0]   result_r;
    logic              busy_r;
    logic              exdone_r;

    // Issue-time decode
    logic              is_div_s;
    logic              sgn1_s;
    logic              sgn2_s;
    logic [XLEN-1:0]   mag_a_s;
    logic [XLEN-1:0]   mag_b_s;
    logic              neg_res_s;
    logic              neg_rem_s;
    logic              div_zero_s;
    logic              div_ovf_s;
    logic              special_s;
    logic [XLEN-1:0]   special_res_s;
    logic              issue_s;
    logic              fast_hit_s;
    logic [XLEN-1:0]   fast_res_s;

    // Iteration and fix-up datapath
    logic [XLEN:0]     mul_sum_s;
    logic [2*XLEN-1:0] mul_step_s;
    logic [XLEN:0]     div_sh_s;   // XLEN+1-bit partial remainder for this step
    logic              div_ge_s;
    logic [XLEN-1:0]   div_rem_s;
    logic [XLEN-1:0]   div_quo_s;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quo_fix_s;
    logic [XLEN-1:0]   rem_fix_s;
    logic [XLEN-1:0]   fix_res_s;

    assign bus.busy   = busy_r;
    assign bus.exdone = exdone_r;
    assign bus.result = result_r;

    // Decode the live request: operand signedness, magnitudes, result signs and special cases.
    always_comb begin
        sgn1_s = 1'b0;
        sgn2_s = 1'b0;
        is_div_s = bus.op[2];
        case (bus.op)
            OP_MULH, OP_DIV, OP_REM: begin
                sgn1_s = 1'b1;
                sgn2_s = 1'b1;
            end
            OP_MULHSU: begin
                sgn1_s = 1'b1;
                sgn2_s = 1'b0;
            end
            default: begin
                sgn1_s = 1'b0;
                sgn2_s = 1'b0;
            end
        endcase
        mag_a_s    = mag_x(bus.rs1, sgn1_s);
        mag_b_s    = mag_x(bus.rs2, sgn2_s);
        neg_res_s  = (sgn1_s & bus.rs1[XLEN-1]) ^ (sgn2_s & bus.rs2[XLEN-1]);
        neg_rem_s  = sgn1_s & bus.rs1[XLEN-1];
        div_zero_s = is_div_s && (bus.rs2 == ZERO_X);
        div_ovf_s  = is_div_s && sgn1_s && (bus.rs1 == MIN_X) && (bus.rs2 == ONES_X);
        special_s  = div_zero_s || div_ovf_s;
        // op[1] distinguishes REM/REMU from DIV/DIVU
        if (div_zero_s) begin
            special_res_s = bus.op[1] ? bus.rs1 : ONES_X;
        end else if (div_ovf_s) begin
            special_res_s = bus.op[1] ? ZERO_X : bus.rs1;
        end else begin
            special_res_s = ZERO_X;
        end
        issue_s = bus.start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
    end

`ifdef MULDIV_FASTMUL_EN
    logic [2*XLEN-1:0] fast_prod_s;
    logic [2*XLEN-1:0] fast_sprod_s;

    // Single-cycle signed/unsigned product of the live operands.
    always_comb begin
        fast_prod_s  = {ZERO_X, mag_a_s} * {ZERO_X, mag_b_s};
        fast_sprod_s = neg_res_s ? neg_2x(fast_prod_s) : fast_prod_s;
        fast_hit_s   = ~is_div_s;
        if (bus.op == OP_MUL) begin
            fast_res_s = fast_sprod_s[XLEN-1:0];
        end else begin
            fast_res_s = fast_sprod_s[2*XLEN-1:XLEN];
        end
    end
`else
    // Without the fast multiplier every multiply takes the iterative path.
    always_comb begin
        fast_hit_s = 1'b0;
        fast_res_s = ZERO_X;
    end
`endif

    // Next-state logic of the control FSM.
    always_comb begin
        state_nx = state_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    if (special_s || fast_hit_s) begin
                        state_nx = ST_DONE;
                    end else begin
                        state_nx = ST_CALC;
                    end
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (cnt_r == CNT_ONE) begin
                    state_nx = ST_FIX;
                end else begin
                    state_nx = ST_CALC;
                end
            end
            ST_FIX:  state_nx = ST_DONE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    // One shift-add / restoring-divide step, plus sign fix-up and half selection.
    always_comb begin
        mul_sum_s  = {1'b0, acc_r[2*XLEN-1:XLEN]} + (acc_r[0] ? {1'b0, opa_r} : {(XLEN+1){1'b0}});
        mul_step_s = {mul_sum_s, acc_r[XLEN-1:1]};

        div_sh_s  = {rem_r, acc_r[XLEN-1]};
        div_ge_s  = (div_sh_s >= {1'b0, opb_r});
        // the true difference is below the divisor, so XLEN bits hold it exactly
        if (div_ge_s) begin
            div_rem_s = div_sh_s[XLEN-1:0] - opb_r;
        end else begin
            div_rem_s = div_sh_s[XLEN-1:0];
        end
        div_quo_s = {acc_r[XLEN-2:0], div_ge_s};

        prod_s    = neg_res_r ? neg_2x(acc_r) : acc_r;
        quo_fix_s = neg_res_r ? neg_x(acc_r[XLEN-1:0]) : acc_r[XLEN-1:0];
        rem_fix_s = neg_rem_r ? neg_x(rem_r) : rem_r;

        case (op_r)
            OP_MUL:                       fix_res_s = prod_s[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_res_s = prod_s[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              fix_res_s = quo_fix_s;
            OP_REM, OP_REMU:              fix_res_s = rem_fix_s;
            default:                      fix_res_s = ZERO_X;
        endcase
    end

    // Operand capture at issue, iteration in CALC, result write-back, registered status.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r     <= {CNTW{1'b0}};
            acc_r     <= {(2*XLEN){1'b0}};
            rem_r     <= ZERO_X;
            opa_r     <= ZERO_X;
            opb_r     <= ZERO_X;
            op_r      <= 3'b000;
            neg_res_r <= 1'b0;
            neg_rem_r <= 1'b0;
            result_r  <= ZERO_X;
            busy_r    <= 1'b0;
            exdone_r  <= 1'b0;
        end else begin
            if (issue_s) begin
                op_r      <= bus.op;
                opa_r     <= mag_a_s;
                opb_r     <= mag_b_s;
                neg_res_r <= neg_res_s;
                neg_rem_r <= neg_rem_s;
                cnt_r     <= CNT_LOAD;
                rem_r     <= ZERO_X;
                acc_r     <= {ZERO_X, (is_div_s ? mag_a_s : mag_b_s)};
                if (special_s) begin
                    result_r <= special_res_s;
                end else if (fast_hit_s) begin
                    result_r <= fast_res_s;
                end
            end else if (state_r == ST_CALC) begin
                cnt_r <= cnt_r - CNT_ONE;
                if (op_r[2]) begin
                    acc_r <= {ZERO_X, div_quo_s};
                    rem_r <= div_rem_s;
                end else begin
                    acc_r <= mul_step_s;
                end
            end else if (state_r == ST_FIX) begin
                result_r <= fix_res_s;
            end
            busy_r   <= (state_nx == ST_CALC) || (state_nx == ST_FIX);
            exdone_r <= (state_nx == ST_DONE);
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: table-driven vectors, randomized ops against an arithmetic
// reference model, and hand-written sequences for ignored/back-to-back
// issue and reset during an operation.
module tb_muldiv_unit;

    localparam int XLEN = 32;
    localparam int ITER_LAT = XLEN + 2;
`ifdef MULDIV_FASTMUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = XLEN + 2;
`endif

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    muldiv_if #(.XLEN(XLEN)) bus ();

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit / 32-bit arithmetic following the RV32M definitions.
    function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ub_s;
        logic [63:0] p;
        int          si, sj;
        sa   = {{32{a[31]}}, a};
        sb   = {{32{b[31]}}, b};
        ub_s = {32'd0, b};
        si   = a;
        sj   = b;
        case (op)
            3'd0: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
            3'd1: begin p = sa * sb;                 return p[63:32]; end
            3'd2: begin p = sa * ub_s;               return p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                else return si / sj;
            end
            3'd5: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                else return a / b;
            end
            3'd6: begin
                if (b == 32'd0) return a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                else return si % sj;
            end
            default: begin
                if (b == 32'd0) return a;
                else return a % b;
            end
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (!op[2]) return MUL_LAT;
        if (b == 32'd0) return 1;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return ITER_LAT;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Issue one op at a negedge, scramble the inputs after issue, and wait for exdone.
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat, output int busy_cnt);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.rs1   = a;
        bus.rs2   = b;
        lat = -1;
        busy_cnt = 0;
        res = 32'd0;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk);
            @(negedge clk);
            bus.start = 1'b0;
            bus.op    = 3'($urandom_range(0, 7));
            bus.rs1   = $urandom;
            bus.rs2   = $urandom;
            if (bus.exdone) begin
                lat = c;
                res = bus.result;
                break;
            end
            if (bus.busy) busy_cnt++;
        end
    endtask

    task automatic run_and_check(input string tag, input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        logic [31:0] res;
        int          lat;
        int          bc;
        do_op(op, a, b, res, lat, bc);
        check({tag, ".result"}, res, exp);
        check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
        check({tag, ".busycycles"}, 32'(bc), 32'(exp_lat - 1));
        // exdone is a single pulse and the result stays put afterwards
        @(posedge clk);
        @(negedge clk);
        check({tag, ".pulse"}, {31'd0, bus.exdone}, 32'd0);
        check({tag, ".hold"}, bus.result, exp);
    endtask

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        int          first;
        int          second;
        int          pulses;

        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.op    = 3'd0;
        bus.rs1   = 32'd0;
        bus.rs2   = 32'd0;

        vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT};
        vecs[1]  = '{3'd1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, MUL_LAT};
        vecs[2]  = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, MUL_LAT};
        vecs[3]  = '{3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, MUL_LAT};
        vecs[4]  = '{3'd4, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD, ITER_LAT};
        vecs[5]  = '{3'd6, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, ITER_LAT};
        vecs[6]  = '{3'd5, 32'd100,        32'd7,          32'd14,        ITER_LAT};
        vecs[7]  = '{3'd7, 32'd100,        32'd7,          32'd2,         ITER_LAT};
        vecs[8]  = '{3'd5, 32'd5,          32'd0,          32'hFFFF_FFFF, 1};
        vecs[9]  = '{3'd6, 32'd5,          32'd0,          32'd5,         1};
        vecs[10] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
        vecs[11] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1};
        vecs[12] = '{3'd5, 32'd0,          32'd3,          32'd0,         ITER_LAT};
        vecs[13] = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset.busy", {31'd0, bus.busy}, 32'd0);
        check("reset.exdone", {31'd0, bus.exdone}, 32'd0);
        check("reset.result", bus.result, 32'd0);
        rst = 1'b0;

        // Directed vector table
        for (int i = 0; i < 14; i++) begin
            run_and_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);
        end

        // Randomized ops against the reference model
        for (int i = 0; i < 150; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = pick_operand();
            rb  = pick_operand();
            run_and_check($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb,
                          ref_res(rop, ra, rb), ref_lat(rop, ra, rb));
        end

        // Start while busy is ignored; back-to-back issue in the DONE cycle
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 3'd5;
        bus.rs1   = 32'd100;
        bus.rs2   = 32'd7;
        first  = 0;
        second = 0;
        pulses = 0;
        for (int c = 1; c <= 90; c++) begin
            @(posedge clk);
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.exdone) begin
                pulses++;
                if (first == 0) begin
                    first = c;
                    check("b2b.first_result", bus.result, 32'd14);
                    bus.start = 1'b1;
                    bus.op    = 3'd6;
                    bus.rs1   = 32'hFFFF_FFF9;
                    bus.rs2   = 32'd2;
                end else if (second == 0) begin
                    second = c;
                    check("b2b.second_result", bus.result, 32'hFFFF_FFFF);
                end
            end
            if (c == 10) begin
                check("b2b.busy_at_10", {31'd0, bus.busy}, 32'd1);
                bus.start = 1'b1;
                bus.op    = 3'd5;
                bus.rs1   = 32'd1;
                bus.rs2   = 32'd1;
            end
            if (c == 35) begin
                check("b2b.busy_at_35", {31'd0, bus.busy}, 32'd1);
            end
        end
        check("b2b.first_cycle", 32'(first), 32'(ITER_LAT));
        check("b2b.second_cycle", 32'(second), 32'(2 * ITER_LAT));
        check("b2b.pulses", 32'(pulses), 32'd2);

        // Reset in the middle of a divide
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 3'd4;
        bus.rs1   = 32'hFFFF_FF9C;
        bus.rs2   = 32'd3;
        pulses = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.exdone) pulses++;
            if (c == 21) begin
                rst = 1'b0;
                check("midrst.busy", {31'd0, bus.busy}, 32'd0);
                check("midrst.result", bus.result, 32'd0);
            end
            if (c == 20) rst = 1'b1;
        end
        check("midrst.no_exdone", 32'(pulses), 32'd0);

        // Reset and start together: start is dropped
        @(negedge clk);
        rst       = 1'b1;
        bus.start = 1'b1;
        bus.op    = 3'd5;
        bus.rs1   = 32'd9;
        bus.rs2   = 32'd3;
        @(posedge clk);
        @(negedge clk);
        rst       = 1'b0;
        bus.start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rststart.busy", {31'd0, bus.busy}, 32'd0);
        check("rststart.exdone", {31'd0, bus.exdone}, 32'd0);
        check("rststart.result", bus.result, 32'd0);

        // A fresh divide after reset completes normally
        run_and_check("postrst.div", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, ITER_LAT);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
